// File: rtl/ecc_ctrl_pkg.sv
// ecc_ctrl_pkg
// Shared definitions for the ECC scalar-multiplication controller:
//   state_t  - controller FSM states
//   OP_ADD / OP_DBL - encodings driven on op_dbl
//   OP_CNT_W - width of the optional operation counters (ECC_CTRL_OPCOUNT_EN)
package ecc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DBL_ISSUE,
    ST_DBL_WAIT,
    ST_ADD_CHECK,
    ST_ADD_ISSUE,
    ST_ADD_WAIT,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_DBL = 1'b1;

  localparam int OP_CNT_W = 32;

endpackage

// File: rtl/ecc_scalar_mult_ctrl.sv
// ecc_scalar_mult_ctrl
// Left-to-right double-and-add sequencer for Q = k*P. One external
// point-operation unit does all field arithmetic; this block only compares
// coordinates and keeps the point at infinity and the P+P / P+(-P) cases
// away from the datapath.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, k, px, py      request pulse and operands (sampled when idle)
//   busy, done            busy while running, one-cycle done pulse
//   qx, qy, q_inf         result (held until next accepted start)
//   op_start, op_dbl      operation issue pulse, 1=double 0=add
//   op_x1..op_y2          operands, stable while an operation is outstanding
//   op_done, op_x3, op_y3 datapath completion and result
//   dbl_count, add_count  issued-operation counters (only with ECC_CTRL_OPCOUNT_EN)
//
// Optional feature macro: ECC_CTRL_OPCOUNT_EN
module ecc_scalar_mult_ctrl
  import ecc_ctrl_pkg::*;
#(
  parameter int N     = 231,
  parameter int K_W   = 231,
  parameter int IDX_W = $clog2(K_W)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [K_W-1:0]      k,
  input  logic [N-1:0]        px,
  input  logic [N-1:0]        py,
  output logic                busy,
  output logic                done,
  output logic [N-1:0]        qx,
  output logic [N-1:0]        qy,
  output logic                q_inf,
`ifdef ECC_CTRL_OPCOUNT_EN
  output logic [OP_CNT_W-1:0] dbl_count,
  output logic [OP_CNT_W-1:0] add_count,
`endif
  output logic                op_start,
  output logic                op_dbl,
  output logic [N-1:0]        op_x1,
  output logic [N-1:0]        op_y1,
  output logic [N-1:0]        op_x2,
  output logic [N-1:0]        op_y2,
  input  logic                op_done,
  input  logic [N-1:0]        op_x3,
  input  logic [N-1:0]        op_y3
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(K_W - 1);

  state_t state, state_next;

  logic [N-1:0]     acc_x, acc_y;
  logic             acc_inf;
  logic [N-1:0]     base_x, base_y;
  logic [K_W-1:0]   k_reg;
  logic [IDX_W-1:0] idx;
  logic             sub_dbl;
  logic             cur_dbl;

  logic k_bit;
  logic load_start, acc_set_inf, acc_load_p, acc_capture;
  logic dec_idx, finish, set_sub, clr_sub;

  assign k_bit = k_reg[idx];

  // Operands come straight from the accumulator and the latched base point;
  // neither changes while an operation is outstanding.
  assign op_x1 = acc_x;
  assign op_y1 = acc_y;
  assign op_x2 = base_x;
  assign op_y2 = base_y;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and control strobes. A doubling substituted for the
  // degenerate P+P addition shares DBL_WAIT; sub_dbl sends its completion
  // to NEXT instead of ADD_CHECK.
  always_comb begin
    state_next  = state;
    op_start    = 1'b0;
    op_dbl      = cur_dbl;
    load_start  = 1'b0;
    acc_set_inf = 1'b0;
    acc_load_p  = 1'b0;
    acc_capture = 1'b0;
    dec_idx     = 1'b0;
    finish      = 1'b0;
    set_sub     = 1'b0;
    clr_sub     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          load_start = 1'b1;
          state_next = ST_DBL_ISSUE;
        end
      end
      ST_DBL_ISSUE: begin
        if (acc_inf) begin
          state_next = ST_ADD_CHECK;
        end else if (acc_y == '0) begin
          acc_set_inf = 1'b1;
          state_next  = ST_ADD_CHECK;
        end else begin
          op_start   = 1'b1;
          op_dbl     = OP_DBL;
          state_next = ST_DBL_WAIT;
        end
      end
      ST_DBL_WAIT: begin
        if (op_done) begin
          acc_capture = 1'b1;
          clr_sub     = 1'b1;
          state_next  = sub_dbl ? ST_NEXT : ST_ADD_CHECK;
        end
      end
      ST_ADD_CHECK: begin
        if (!k_bit) begin
          state_next = ST_NEXT;
        end else if (acc_inf) begin
          acc_load_p = 1'b1;
          state_next = ST_NEXT;
        end else if (acc_x == base_x && acc_y == base_y) begin
          op_start   = 1'b1;
          op_dbl     = OP_DBL;
          set_sub    = 1'b1;
          state_next = ST_DBL_WAIT;
        end else if (acc_x == base_x) begin
          acc_set_inf = 1'b1;
          state_next  = ST_NEXT;
        end else begin
          state_next = ST_ADD_ISSUE;
        end
      end
      ST_ADD_ISSUE: begin
        op_start   = 1'b1;
        op_dbl     = OP_ADD;
        state_next = ST_ADD_WAIT;
      end
      ST_ADD_WAIT: begin
        if (op_done) begin
          acc_capture = 1'b1;
          state_next  = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (idx == '0) begin
          state_next = ST_DONE;
        end else begin
          dec_idx    = 1'b1;
          state_next = ST_DBL_ISSUE;
        end
      end
      ST_DONE: begin
        finish     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Accumulator, latched operands, bit index and the registered result.
  // done and busy are registered so that done lines up with valid qx/qy.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_x   <= '0;
      acc_y   <= '0;
      acc_inf <= 1'b0;
      base_x  <= '0;
      base_y  <= '0;
      k_reg   <= '0;
      idx     <= '0;
      sub_dbl <= 1'b0;
      cur_dbl <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      qx      <= '0;
      qy      <= '0;
      q_inf   <= 1'b0;
    end else begin
      done <= finish;
      if (load_start) begin
        k_reg   <= k;
        base_x  <= px;
        base_y  <= py;
        acc_inf <= 1'b1;
        idx     <= IDX_LAST;
        sub_dbl <= 1'b0;
        busy    <= 1'b1;
      end
      if (acc_set_inf) begin
        acc_inf <= 1'b1;
      end
      if (acc_load_p) begin
        acc_x   <= base_x;
        acc_y   <= base_y;
        acc_inf <= 1'b0;
      end
      if (acc_capture) begin
        acc_x <= op_x3;
        acc_y <= op_y3;
      end
      if (set_sub) begin
        sub_dbl <= 1'b1;
      end
      if (clr_sub) begin
        sub_dbl <= 1'b0;
      end
      if (op_start) begin
        cur_dbl <= op_dbl;
      end
      if (dec_idx) begin
        idx <= idx - 1'b1;
      end
      if (finish) begin
        qx    <= acc_inf ? '0 : acc_x;
        qy    <= acc_inf ? '0 : acc_y;
        q_inf <= acc_inf;
        busy  <= 1'b0;
      end
    end
  end

`ifdef ECC_CTRL_OPCOUNT_EN
  // Issued-operation counters; a substituted doubling counts as a doubling.
  always_ff @(posedge clk) begin
    if (reset) begin
      dbl_count <= '0;
      add_count <= '0;
    end else if (load_start) begin
      dbl_count <= '0;
      add_count <= '0;
    end else if (op_start) begin
      if (op_dbl == OP_DBL) begin
        dbl_count <= dbl_count + 1'b1;
      end else begin
        add_count <= add_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/ecc_scalar_mult_ctrl.md
Name: ecc_scalar_mult_ctrl

Overview:
- Sequences left-to-right double-and-add scalar multiplication Q = k·P over a prime-field curve.
- Drives one shared external point-operation unit (point addition/doubling datapath) through a start/done handshake.
- Tracks the point at infinity and degenerate additions itself, so the datapath never sees an undefined case (zero x-difference).
- Sits between the top-level ECC command interface and the point-arithmetic datapath.

Parameters:
- N, 231, field element / coordinate width in bits.
- K_W, 231, scalar width in bits.
- IDX_W, $clog2(K_W), bit-index counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; accepted only when busy=0.
- k  in  K_W  scalar; sampled on the accepted start.
- px  in  N  base point x; sampled on the accepted start.
- py  in  N  base point y; sampled on the accepted start.
- busy  out  1  high from the cycle after the accepted start until done.
- done  out  1  one-cycle pulse; result valid.
- qx  out  N  result x; held until the next accepted start.
- qy  out  N  result y; held until the next accepted start.
- q_inf  out  1  result is the point at infinity (qx=qy=0).
- op_start  out  1  one-cycle pulse; issues one operation to the datapath.
- op_dbl  out  1  1=double (x1,y1); 0=add (x1,y1)+(x2,y2).
- op_x1, op_y1, op_x2, op_y2  out  N each  operands; stable from op_start until op_done.
- op_done  in  1  datapath result-valid pulse.
- op_x3, op_y3  in  N each  datapath result; captured on op_done.

Behaviour:
- Clock and reset: one clock. Synchronous active-high reset returns the FSM to IDLE and clears all outputs and registers to 0, including any operation in progress. The datapath shares the same reset.
- Internal registers: acc_x, acc_y, acc_inf, base point, scalar copy, and bit index idx.
- FSM states: IDLE, DBL_ISSUE, DBL_WAIT, ADD_CHECK, ADD_ISSUE, ADD_WAIT, NEXT, DONE.
- IDLE: on start, latch k/px/py, set acc_inf=1, idx=K_W-1, busy=1, go to DBL_ISSUE. A start while busy is ignored.
- DBL_ISSUE:
  - If acc_inf, skip directly to ADD_CHECK.
  - Else if acc_y==0, set acc_inf=1 and go to ADD_CHECK.
  - Else pulse op_start with op_dbl=1 and operands acc, then go to DBL_WAIT.
- DBL_WAIT: on op_done, acc<=op_x3/op_y3, go to ADD_CHECK.
- ADD_CHECK:
  - If k[idx]==0, go to NEXT.
  - If acc_inf, acc<=P, acc_inf=0, then NEXT (no op issued).
  - If acc_x==px and acc_y==py, substitute a doubling: go to DBL_WAIT path, with op_dbl=1 pulsed here.
  - If acc_x==px and acc_y!=py, set acc_inf=1 and go to NEXT (P + (−P)).
  - Otherwise go to ADD_ISSUE.
- ADD_ISSUE: pulse op_start, op_dbl=0, x1/y1=acc, x2/y2=P. Go to ADD_WAIT; on op_done capture acc, then NEXT.
- Substituted double: its completion returns to NEXT, not ADD_CHECK. Track this with a one-bit flag.
- NEXT: if idx==0, go to DONE; else idx<=idx-1 and go to DBL_ISSUE.
- DONE: qx/qy<=acc (0 if acc_inf), q_inf<=acc_inf, done=1 for one cycle, busy=0, return to IDLE.
- Handshake: at most one operation outstanding. op_start never reasserts before op_done. op_done outside a WAIT state is ignored.
- Latency:
  - No per-bit stall beyond datapath latency, plus a fixed 2–3 control cycles per bit.
  - k=0 completes in K_W·3+2 cycles with zero ops issued.
- Arithmetic: the block performs only equality compares; all field arithmetic is done in the datapath.

Optional Feature:
- Macro ECC_CTRL_OPCOUNT_EN.
- Defined: adds outputs dbl_count and add_count (32 bits each). They clear on accepted start, increment per issued doubling/addition (a substituted double counts as a doubling), and hold after done.
- Undefined: the ports and counters are absent.

Decomposition:
- Package ecc_ctrl_pkg: FSM state enum, OP_ADD/OP_DBL encodings, counter width constant.
- No sub-module needed. Optionally split out ecc_bit_scanner (idx counter plus k[idx] mux).

Test Plan:
All scenarios use curve p=17, y²=x³+2x+2, P=G=(5,1), with a behavioural datapath model of 5-cycle latency.
- k=0 -> done, q_inf=1, qx=qy=0, no op_start pulses.
- k=1 -> (5,1), q_inf=0, zero ops issued.
- k=2 -> (6,3); 1 double, 0 adds. k=9 -> (7,6); 3 doubles, 1 add.
- k=19 -> q_inf=1; 4 doubles, 1 add; final add detected as P+(−P) with no op issued.
- k=21 -> (6,3); final add hits acc==P, substituted doubling; 5 doubles, 1 add total.
- Second start while busy -> ignored, result unchanged. Reset asserted mid DBL_WAIT -> next cycle IDLE, busy=0, all outputs 0, and a fresh k=2 run yields (6,3).
